universal_shift_reg: RTL and testbench



---
 rtl/shift_pkg.sv | 24 ++
 rtl/universal_shift_reg.sv | 113 +++++++++++
 tb/tb_universal_shift_reg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register.
//   shift_mode_t : 3-bit operation select. Encoding 7 is unused and is
//                  treated as HOLD by the register.
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHR   = 3'd1,
        SHL   = 3'd2,
        LOAD  = 3'd3,
        ROTR  = 3'd4,
        ROTL  = 3'd5,
        CLEAR = 3'd6
    } shift_mode_t;

    // True for the operations that advance the shift counter.
    function automatic logic mode_is_shift(input logic [2:0] m);
        return (m == SHR) || (m == SHL) || (m == ROTR) || (m == ROTL);
    endfunction

endpackage : shift_pkg

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Parametrised universal shift register with parallel load, bidirectional
// shift, rotate, synchronous clear, clock enable and a word counter that
// pulses word_done after every NBITS-th shift/rotate (serialiser /
// deserialiser use).
//
// Ports
//   clk_2       in   divided board clock, rising edge active
//   reset_n     in   asynchronous active-low reset
//   en          in   clock enable, 0 holds every register
//   mode        in   [2:0] operation select (shift_mode_t)
//   ser_in_r    in   bit entering the MSB on shift right
//   ser_in_l    in   bit entering the LSB on shift left
//   par_in      in   [NBITS-1:0] parallel load data
//   q           out  [NBITS-1:0] register contents
//   ser_out_r   out  q[0]
//   ser_out_l   out  q[NBITS-1]
//   shift_count out  [CW-1:0] shifts since last load, clear or word end
//   word_done   out  one-cycle pulse after the NBITS-th shift
// -----------------------------------------------------------------------------
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int NBITS = 4,
    localparam int CW   = $clog2(NBITS + 1)
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [NBITS-1:0] par_in,
    output logic [NBITS-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CW-1:0]    shift_count,
    output logic             word_done
);

    logic [NBITS-1:0] q_reg;
    logic [NBITS-1:0] q_next;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             done_reg;
    logic             done_next;
    logic             is_shift;
    logic [CW-1:0]    count_inc;

    // Data path next state.
    always_comb begin
        q_next = q_reg;
        if (en) begin
            case (mode)
                SHR:     q_next = {ser_in_r, q_reg[NBITS-1:1]};
                SHL:     q_next = {q_reg[NBITS-2:0], ser_in_l};
                LOAD:    q_next = par_in;
                ROTR:    q_next = {q_reg[0], q_reg[NBITS-1:1]};
                ROTL:    q_next = {q_reg[NBITS-2:0], q_reg[NBITS-1]};
                CLEAR:   q_next = '0;
                default: q_next = q_reg;   // HOLD and the unused code 7
            endcase
        end
    end

    // Counter / word-end next state. word_done only ever lasts one cycle,
    // so its default is 0 rather than hold.
    always_comb begin
        is_shift   = mode_is_shift(mode);
        count_inc  = count_reg + CW'(1);
        count_next = count_reg;
        done_next  = 1'b0;
        if (en) begin
            if (is_shift) begin
                if (count_inc == CW'(NBITS)) begin
                    count_next = '0;
                    done_next  = 1'b1;
                end else begin
                    count_next = count_inc;
                end
            end else if ((mode == LOAD) || (mode == CLEAR)) begin
                // A load or clear abandons the partial word, even at NBITS-1.
                count_next = '0;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    assign q           = q_reg;
    assign ser_out_r   = q_reg[0];
    assign ser_out_l   = q_reg[NBITS-1];
    assign shift_count = count_reg;
    assign word_done   = done_reg;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed test of universal_shift_reg (NBITS=4) with hand-computed values.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;
    import shift_pkg::*;

    localparam int NBITS = 4;
    localparam int CW    = 3;

    logic             clk_2 = 1'b0;
    logic             reset_n;
    logic             en;
    logic [2:0]       mode;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [NBITS-1:0] par_in;
    logic [NBITS-1:0] q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CW-1:0]    shift_count;
    logic             word_done;

    int checks_total  = 0;
    int checks_passed = 0;

    universal_shift_reg #(.NBITS(NBITS)) dut (
        .clk_2       (clk_2),
        .reset_n     (reset_n),
        .en          (en),
        .mode        (mode),
        .ser_in_r    (ser_in_r),
        .ser_in_l    (ser_in_l),
        .par_in      (par_in),
        .q           (q),
        .ser_out_r   (ser_out_r),
        .ser_out_l   (ser_out_l),
        .shift_count (shift_count),
        .word_done   (word_done)
    );

    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one operation across one rising edge, then settle 1 time unit.
    task automatic op(input logic [2:0] m, input logic sr, input logic sl,
                      input logic [3:0] p);
        mode = m; ser_in_r = sr; ser_in_l = sl; par_in = p;
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [3:0] eq,
                        input logic [2:0] ec, input logic ed);
        check({tag, ".q"},    32'(q),           32'(eq));
        check({tag, ".cnt"},  32'(shift_count), 32'(ec));
        check({tag, ".done"}, 32'(word_done),   32'(ed));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; en = 1'b1; mode = HOLD;
        ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 4'h0;
        @(posedge clk_2); #1;
        chk3("reset", 4'h0, 3'd0, 1'b0);
        reset_n = 1'b1;

        // Mid-cycle asynchronous reset.
        op(LOAD, 0, 0, 4'b1011);
        check("load1011", 32'(q), 32'hB);
        #2 reset_n = 1'b0;
        #1 chk3("async_rst", 4'h0, 3'd0, 1'b0);
        reset_n = 1'b1;
        op(LOAD, 0, 0, 4'b0110);
        check("load0110", 32'(q), 32'h6);

        // Shift right / deserialise 1,0,1,1.
        op(CLEAR, 0, 0, 4'h0);
        op(SHR, 1, 0, 4'h0); chk3("shr1", 4'b1000, 3'd1, 1'b0);
        op(SHR, 0, 0, 4'h0); chk3("shr2", 4'b0100, 3'd2, 1'b0);
        op(SHR, 1, 0, 4'h0); chk3("shr3", 4'b1010, 3'd3, 1'b0);
        op(SHR, 1, 0, 4'h0); chk3("shr4", 4'b1101, 3'd0, 1'b1);
        check("shr4.sor", 32'(ser_out_r), 32'd1);
        op(HOLD, 0, 0, 4'h0); chk3("hold", 4'b1101, 3'd0, 1'b0);

        // Shift left.
        op(LOAD, 0, 0, 4'b1001);
        check("shl.sol_pre", 32'(ser_out_l), 32'd1);
        op(SHL, 0, 0, 4'h0); chk3("shl", 4'b0010, 3'd1, 1'b0);
        check("shl.sol", 32'(ser_out_l), 32'd0);

        // Rotate.
        op(LOAD, 0, 0, 4'b1000);
        op(ROTR, 1, 1, 4'h0); chk3("rotr1", 4'b0100, 3'd1, 1'b0);
        op(ROTR, 1, 1, 4'h0); chk3("rotr2", 4'b0010, 3'd2, 1'b0);
        op(ROTR, 1, 1, 4'h0); chk3("rotr3", 4'b0001, 3'd3, 1'b0);
        op(ROTR, 1, 1, 4'h0); chk3("rotr4", 4'b1000, 3'd0, 1'b1);
        op(ROTL, 1, 1, 4'h0); chk3("rotl1", 4'b0001, 3'd1, 1'b0);

        // Enable gap preserves the count.
        op(CLEAR, 0, 0, 4'h0);
        op(SHR, 1, 0, 4'h0);
        op(SHR, 1, 0, 4'h0);
        op(SHR, 1, 0, 4'h0); chk3("en_pre", 4'b1110, 3'd3, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op(SHR, 0, 0, 4'h0); chk3("en_off", 4'b1110, 3'd3, 1'b0);
        end
        en = 1'b1;
        op(SHR, 1, 0, 4'h0); chk3("en_word", 4'b1111, 3'd0, 1'b1);

        // LOAD at count NBITS-1 cancels the word.
        op(SHR, 0, 0, 4'h0);
        op(SHR, 0, 0, 4'h0);
        op(SHR, 0, 0, 4'h0); chk3("ld_pre", 4'b0001, 3'd3, 1'b0);
        op(LOAD, 0, 0, 4'b1010); chk3("ld_at3", 4'b1010, 3'd0, 1'b0);
        op(SHR, 0, 0, 4'h0); chk3("ld_after", 4'b0101, 3'd1, 1'b0);

        // Back-to-back words, no gap cycle: pulse after shifts 4 and 8.
        op(CLEAR, 0, 0, 4'h0);
        for (int i = 1; i <= 8; i++) begin
            op(SHL, 0, 1, 4'h0);
            check("b2b.done", 32'(word_done), 32'((i % 4) == 0));
            check("b2b.cnt",  32'(shift_count), 32'(i % 4));
        end

        // Reserved code and clear.
        op(LOAD, 0, 0, 4'b1111);
        op(3'd7, 1, 1, 4'h0); chk3("rsvd7", 4'b1111, 3'd0, 1'b0);
        op(SHL, 0, 0, 4'h0);
        op(CLEAR, 0, 0, 4'h0); chk3("clear", 4'b0000, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_universal_shift_reg
